// File: rtl/hwpf_lru_filter.sv
// hwpf_lru_filter
// Recency-ordered address filter for the hardware prefetchers. It remembers the
// last DEPTH cache lines that were requested or prefetched, so that prefetch
// candidates that are already in flight or were recently issued can be dropped.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   flush_i          clear all entries (wins over everything else)
//   lock_i           freeze state; inserts and invalidates are ignored
//   ins_valid_i/ins_addr_i     INSERTS insert ports, applied in port order
//   lkp_addr_i/lkp_hit_o       LOOKUPS combinational lookups on registered state
//   inv_valid_i/inv_addr_i     invalidate one line
//   evict_valid_o/evict_addr_o registered per-port eviction report (one cycle)
//   occupancy_o, full_o        registered count of valid entries
module hwpf_lru_filter #(
    parameter int DEPTH       = 8,
    parameter int INSERTS     = 2,
    parameter int LOOKUPS     = 2,
    parameter int ADDR_W      = 40,
    parameter int OFFSET_BITS = 6,
    parameter int POLICY      = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic                              lock_i,
    input  logic [INSERTS-1:0]                ins_valid_i,
    input  logic [INSERTS-1:0][ADDR_W-1:0]    ins_addr_i,
    input  logic [LOOKUPS-1:0][ADDR_W-1:0]    lkp_addr_i,
    output logic [LOOKUPS-1:0]                lkp_hit_o,
    input  logic                              inv_valid_i,
    input  logic [ADDR_W-1:0]                 inv_addr_i,
    output logic [INSERTS-1:0]                evict_valid_o,
    output logic [INSERTS-1:0][ADDR_W-1:0]    evict_addr_o,
    output logic [$clog2(DEPTH+1)-1:0]        occupancy_o,
    output logic                              full_o
);

    localparam int LINE_W = ADDR_W - OFFSET_BITS;
    localparam int RANK_W = $clog2(DEPTH);
    localparam int OCC_W  = $clog2(DEPTH + 1);

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [RANK_W-1:0] rank_t;
    typedef logic [RANK_W-1:0] idx_t;

    // Each entry carries a rank: 0 is the LRU end, DEPTH-1 is the MRU end.
    // The ranks always form a permutation of 0..DEPTH-1.
    logic [DEPTH-1:0]          valid_q, valid_d;
    line_t [DEPTH-1:0]         line_q, line_d;
    rank_t [DEPTH-1:0]         rank_q, rank_d;
    logic [INSERTS-1:0]        evictValid_q, evictValid_d;
    line_t [INSERTS-1:0]       evictLine_q, evictLine_d;
    logic [OCC_W-1:0]          occ_q, occ_d;
    logic                      full_q, full_d;

    // Offset bits of the inputs never take part in matching.
    logic unusedOffsetBits;
    assign unusedOffsetBits = ^{inv_addr_i[OFFSET_BITS-1:0], ins_addr_i, lkp_addr_i};

    // Lookups see only registered state, so a same-cycle insert is invisible.
    always_comb begin
        lkp_hit_o = '0;
        for (int l = 0; l < LOOKUPS; l++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (valid_q[e] && line_q[e] == lkp_addr_i[l][ADDR_W-1:OFFSET_BITS]) begin
                    lkp_hit_o[l] = 1'b1;
                end
            end
        end
    end

    // Next state is built by applying each active insert port in order on a
    // working copy of the table, then the invalidate, so a later port sees
    // the effect of an earlier one in the same cycle.
    always_comb begin : updateComb
        logic  hit;
        logic  free;
        idx_t  hitIdx;
        idx_t  freeIdx;
        idx_t  lruIdx;
        idx_t  tgt;
        rank_t oldRank;
        line_t insLine;
        line_t invLine;

        valid_d      = valid_q;
        line_d       = line_q;
        rank_d       = rank_q;
        evictValid_d = '0;
        evictLine_d  = '0;
        hit          = 1'b0;
        free         = 1'b0;
        hitIdx       = '0;
        freeIdx      = '0;
        lruIdx       = '0;
        tgt          = '0;
        oldRank      = '0;
        insLine      = '0;
        invLine      = '0;

        if (flush_i) begin
            valid_d = '0;
            line_d  = '0;
            for (int e = 0; e < DEPTH; e++) begin
                rank_d[e] = rank_t'(e);
            end
        end else if (!lock_i) begin
            for (int p = 0; p < INSERTS; p++) begin
                if (ins_valid_i[p]) begin
                    insLine = ins_addr_i[p][ADDR_W-1:OFFSET_BITS];
                    hit     = 1'b0;
                    free    = 1'b0;
                    hitIdx  = '0;
                    freeIdx = '0;
                    lruIdx  = '0;
                    // Descending scan leaves the lowest-index free entry selected.
                    for (int e = DEPTH - 1; e >= 0; e--) begin
                        if (valid_d[e] && line_d[e] == insLine) begin
                            hit    = 1'b1;
                            hitIdx = idx_t'(e);
                        end
                        if (!valid_d[e]) begin
                            free    = 1'b1;
                            freeIdx = idx_t'(e);
                        end
                        if (rank_d[e] == '0) begin
                            lruIdx = idx_t'(e);
                        end
                    end

                    if (hit) begin
                        tgt = hitIdx;
                    end else if (free) begin
                        tgt = freeIdx;
                    end else begin
                        tgt             = lruIdx;
                        evictValid_d[p] = 1'b1;
                        evictLine_d[p]  = line_d[lruIdx];
                    end

                    // FIFO keeps allocation order, so a hit does not promote.
                    if (!hit || POLICY == 0) begin
                        oldRank = rank_d[tgt];
                        for (int e = 0; e < DEPTH; e++) begin
                            if (rank_d[e] > oldRank) begin
                                rank_d[e] = rank_d[e] - 1'b1;
                            end
                        end
                        rank_d[tgt] = rank_t'(DEPTH - 1);
                    end
                    valid_d[tgt] = 1'b1;
                    line_d[tgt]  = insLine;
                end
            end

            if (inv_valid_i) begin
                invLine = inv_addr_i[ADDR_W-1:OFFSET_BITS];
                hit     = 1'b0;
                hitIdx  = '0;
                for (int e = 0; e < DEPTH; e++) begin
                    if (valid_d[e] && line_d[e] == invLine) begin
                        hit    = 1'b1;
                        hitIdx = idx_t'(e);
                    end
                end
                // The freed entry drops to the LRU end; everything older shifts up.
                if (hit) begin
                    oldRank = rank_d[hitIdx];
                    for (int e = 0; e < DEPTH; e++) begin
                        if (rank_d[e] < oldRank) begin
                            rank_d[e] = rank_d[e] + 1'b1;
                        end
                    end
                    rank_d[hitIdx]  = '0;
                    valid_d[hitIdx] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        occ_d = '0;
        for (int e = 0; e < DEPTH; e++) begin
            occ_d = occ_d + OCC_W'(valid_d[e]);
        end
        full_d = (occ_d == OCC_W'(DEPTH));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            line_q  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                rank_q[e] <= rank_t'(e);
            end
            evictValid_q <= '0;
            evictLine_q  <= '0;
            occ_q        <= '0;
            full_q       <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            line_q       <= line_d;
            rank_q       <= rank_d;
            evictValid_q <= evictValid_d;
            evictLine_q  <= evictLine_d;
            occ_q        <= occ_d;
            full_q       <= full_d;
        end
    end

    always_comb begin
        for (int p = 0; p < INSERTS; p++) begin
            evict_addr_o[p] = {evictLine_q[p], {OFFSET_BITS{1'b0}}};
        end
    end

    assign evict_valid_o = evictValid_q;
    assign occupancy_o   = occ_q;
    assign full_o        = full_q;

endmodule
